// File: rtl/dcache_ctrl_if.sv
// Pipeline-side load/store request and backing-memory word port of the data cache.
interface dcache_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       Write_Data;
  logic [31:0]       Read_data;
  logic              Stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport slave (
    input  MemRead, MemWrite, Address, Write_Data, mem_ready, mem_rdata,
    output Read_data, Stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output MemRead, MemWrite, Address, Write_Data, mem_ready, mem_rdata,
    input  Read_data, Stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits complete combinationally; misses stall while the victim is written back and the line refilled.
module dcache_ctrl #(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_W         = 32
) (
  input logic         CLK,
  input logic         RESET,
  dcache_ctrl_if.slave bus
);
  localparam int unsigned OffW = $clog2(WORDS_PER_LINE);
  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = ADDR_W - IdxW - OffW - 2;
  localparam logic [OffW-1:0] LastCnt = OffW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {StIdle, StWb, StRefill} state_e;

  state_e            state_q, state_d;
  logic [OffW-1:0]   cnt_q, cnt_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TagW-1:0]   tag_q  [NUM_LINES];
  logic [31:0]       data_q [NUM_LINES][WORDS_PER_LINE];
  logic [IdxW-1:0]   miss_idx_q;
  logic [TagW-1:0]   miss_tag_q;

  logic [OffW-1:0]   off;
  logic [IdxW-1:0]   idx;
  logic [TagW-1:0]   tag;
  logic              req, hit, miss;
  logic              wr_hit, fill_we, fill_done;
  logic              unused_addr;

  assign off  = bus.Address[2 +: OffW];
  assign idx  = bus.Address[OffW+2 +: IdxW];
  assign tag  = bus.Address[ADDR_W-1 -: TagW];
  assign req  = bus.MemRead | bus.MemWrite;
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign miss = req && !hit;
  assign unused_addr = ^bus.Address[1:0];

  assign bus.Read_data = bus.MemRead ? data_q[idx][off] : '0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.Stall     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    wr_hit        = 1'b0;
    fill_we       = 1'b0;
    fill_done     = 1'b0;
    // While in reset every pending request looks like a miss and memory stays idle.
    if (!RESET) begin
      state_d   = StIdle;
      cnt_d     = '0;
      bus.Stall = req;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss) begin
            bus.Stall = 1'b1;
            cnt_d     = '0;
            state_d   = (valid_q[idx] && dirty_q[idx]) ? StWb : StRefill;
          end else if (bus.MemWrite) begin
            wr_hit = 1'b1;
          end
        end
        StWb: begin
          bus.Stall     = 1'b1;
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = {tag_q[miss_idx_q], miss_idx_q, cnt_q, 2'b00};
          bus.mem_wdata = data_q[miss_idx_q][cnt_q];
          if (bus.mem_ready) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) state_d = StRefill;
          end
        end
        StRefill: begin
          bus.Stall    = 1'b1;
          bus.mem_req  = 1'b1;
          bus.mem_addr = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
          if (bus.mem_ready) begin
            fill_we = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              fill_done = 1'b1;
              state_d   = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fill_done) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (wr_hit) dirty_q[idx] <= 1'b1;
    end
  end

  // Arrays and the captured miss address are not reset; valid bits guard their contents.
  always_ff @(posedge CLK) begin
    if (RESET && state_q == StIdle && miss) begin
      miss_idx_q <= idx;
      miss_tag_q <= tag;
    end
    if (fill_done) tag_q[miss_idx_q] <= miss_tag_q;
    if (fill_we) data_q[miss_idx_q][cnt_q] <= bus.mem_rdata;
    if (wr_hit) data_q[idx][off] <= bus.Write_Data;
  end
endmodule
